// File: rtl/mem_lock_arbiter.sv
// Shared data-memory and lock-table arbiter for C cores.
// Memory and lock paths each run a two-state round-robin decision loop.
module mem_lock_arbiter #(
    parameter int C     = 8,
    parameter int LOCKS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [C-1:0]      main_mem_read_request,
    input  logic [C-1:0]      main_mem_write_request,
    input  logic [16*C-1:0]   req_read_adr,
    input  logic [16*C-1:0]   req_write_adr,
    input  logic [16*C-1:0]   req_write_dat,
    output logic [C-1:0]      main_mem_ac,
    output logic [15:0]       mem_read_adr,
    output logic [15:0]       mem_write_adr,
    output logic [15:0]       mem_write_dat,
    output logic              mem_write,
    input  logic [C-1:0]      lock_en,
    input  logic [C-1:0]      unlock_en,
    input  logic [10*C-1:0]   lock_adr,
    output logic [C-1:0]      lock_ac
);

    localparam int CW = (C > 1) ? $clog2(C) : 1;
    localparam int LW = (LOCKS > 1) ? $clog2(LOCKS) : 1;

    typedef enum logic {
        ARB  = 1'b0,
        TURN = 1'b1
    } arb_state_t;

    // First set bit after ptr with wrap; scanning backwards lets the nearest hit win.
    function automatic logic [CW-1:0] rr_pick(input logic [C-1:0] req, input logic [CW-1:0] ptr);
        logic [CW-1:0] pick;
        logic [CW-1:0] idx;
        pick = ptr;
        for (int k = C; k >= 1; k--) begin
            idx = CW'((int'(ptr) + k) % C);
            if (req[idx]) begin
                pick = idx;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    function automatic logic [C-1:0] onehot(input logic [CW-1:0] idx);
        return C'(1) << idx;
    endfunction

    // ------------------------------------------------------------------
    // Memory path
    // ------------------------------------------------------------------
    arb_state_t     mem_state_r;
    logic [CW-1:0]  mem_ptr_r;
    logic [C-1:0]   mem_req_s;
    logic [CW-1:0]  mem_win_s;
    logic [15:0]    win_rd_adr_s;
    logic [15:0]    win_wr_adr_s;
    logic [15:0]    win_wr_dat_s;
    logic           win_wr_s;

    // Round-robin winner and AND-OR steering of its address/data.
    always_comb begin
        mem_req_s    = main_mem_read_request | main_mem_write_request;
        mem_win_s    = rr_pick(mem_req_s, mem_ptr_r);
        win_rd_adr_s = 16'h0000;
        win_wr_adr_s = 16'h0000;
        win_wr_dat_s = 16'h0000;
        win_wr_s     = 1'b0;
        for (int i = 0; i < C; i++) begin
            win_rd_adr_s = win_rd_adr_s | ({16{mem_win_s == CW'(i)}} & req_read_adr[16*i +: 16]);
            win_wr_adr_s = win_wr_adr_s | ({16{mem_win_s == CW'(i)}} & req_write_adr[16*i +: 16]);
            win_wr_dat_s = win_wr_dat_s | ({16{mem_win_s == CW'(i)}} & req_write_dat[16*i +: 16]);
            win_wr_s     = win_wr_s | ((mem_win_s == CW'(i)) & main_mem_write_request[i]);
        end
    end

    // Memory FSM: decide in ARB, present the registered grant during TURN.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_state_r   <= ARB;
            mem_ptr_r     <= CW'(C - 1);
            main_mem_ac   <= '0;
            mem_write     <= 1'b0;
            mem_read_adr  <= 16'h0000;
            mem_write_adr <= 16'h0000;
            mem_write_dat <= 16'h0000;
        end else begin
            case (mem_state_r)
                ARB: begin
                    if (|mem_req_s) begin
                        main_mem_ac   <= onehot(mem_win_s);
                        mem_write     <= win_wr_s;
                        mem_read_adr  <= win_rd_adr_s;
                        mem_write_adr <= win_wr_adr_s;
                        mem_write_dat <= win_wr_dat_s;
                        mem_ptr_r     <= mem_win_s;
                        mem_state_r   <= TURN;
                    end else begin
                        main_mem_ac <= '0;
                        mem_write   <= 1'b0;
                    end
                end
                TURN: begin
                    main_mem_ac <= '0;
                    mem_write   <= 1'b0;
                    mem_state_r <= ARB;
                end
                default: begin
                    main_mem_ac <= '0;
                    mem_write   <= 1'b0;
                    mem_state_r <= ARB;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Lock path
    // ------------------------------------------------------------------
    arb_state_t     lk_state_r;
    logic [CW-1:0]  lk_ptr_r;
    logic [LOCKS-1:0] lk_valid_r;
    logic [9:0]     lk_adr_r   [LOCKS];
    logic [CW-1:0]  lk_owner_r [LOCKS];

    logic [C-1:0]   own_hit_s;
    logic [C-1:0]   other_hit_s;
    logic [C-1:0]   elig_s;
    logic           table_full_s;
    logic [LW-1:0]  free_idx_s;
    logic [CW-1:0]  lk_win_s;
    logic [9:0]     lk_win_adr_s;
    logic           lk_win_unlock_s;
    logic           lk_win_own_s;

    // Eligibility against the current table: a blocked lock neither acks nor moves the pointer.
    always_comb begin
        own_hit_s    = '0;
        other_hit_s  = '0;
        table_full_s = &lk_valid_r;
        free_idx_s   = '0;
        for (int e = LOCKS - 1; e >= 0; e--) begin
            if (!lk_valid_r[e]) begin
                free_idx_s = LW'(e);
            end else begin
                free_idx_s = free_idx_s;
            end
        end
        for (int i = 0; i < C; i++) begin
            for (int e = 0; e < LOCKS; e++) begin
                own_hit_s[i]   = own_hit_s[i] | (lk_valid_r[e] & (lk_adr_r[e] == lock_adr[10*i +: 10])
                                                 & (lk_owner_r[e] == CW'(i)));
                other_hit_s[i] = other_hit_s[i] | (lk_valid_r[e] & (lk_adr_r[e] == lock_adr[10*i +: 10])
                                                   & (lk_owner_r[e] != CW'(i)));
            end
        end
        elig_s = unlock_en | (lock_en & (own_hit_s | (~other_hit_s & {C{~table_full_s}})));
        lk_win_s        = rr_pick(elig_s, lk_ptr_r);
        lk_win_adr_s    = 10'h000;
        lk_win_unlock_s = 1'b0;
        lk_win_own_s    = 1'b0;
        for (int i = 0; i < C; i++) begin
            lk_win_adr_s    = lk_win_adr_s | ({10{lk_win_s == CW'(i)}} & lock_adr[10*i +: 10]);
            lk_win_unlock_s = lk_win_unlock_s | ((lk_win_s == CW'(i)) & unlock_en[i]);
            lk_win_own_s    = lk_win_own_s | ((lk_win_s == CW'(i)) & own_hit_s[i]);
        end
    end

    // Lock FSM and table: one update per decision, unlock takes precedence over lock.
    always_ff @(posedge clk) begin
        if (reset) begin
            lk_state_r <= ARB;
            lk_ptr_r   <= CW'(C - 1);
            lock_ac    <= '0;
            lk_valid_r <= '0;
            for (int e = 0; e < LOCKS; e++) begin
                lk_adr_r[e]   <= 10'h000;
                lk_owner_r[e] <= '0;
            end
        end else begin
            case (lk_state_r)
                ARB: begin
                    if (|elig_s) begin
                        lock_ac    <= onehot(lk_win_s);
                        lk_ptr_r   <= lk_win_s;
                        lk_state_r <= TURN;
                        if (lk_win_unlock_s) begin
                            for (int e = 0; e < LOCKS; e++) begin
                                if (lk_valid_r[e] && (lk_adr_r[e] == lk_win_adr_s) &&
                                    (lk_owner_r[e] == lk_win_s)) begin
                                    lk_valid_r[e] <= 1'b0;
                                end
                            end
                        end else if (!lk_win_own_s) begin
                            lk_valid_r[free_idx_s] <= 1'b1;
                            lk_adr_r[free_idx_s]   <= lk_win_adr_s;
                            lk_owner_r[free_idx_s] <= lk_win_s;
                        end
                    end else begin
                        lock_ac <= '0;
                    end
                end
                TURN: begin
                    lock_ac    <= '0;
                    lk_state_r <= ARB;
                end
                default: begin
                    lock_ac    <= '0;
                    lk_state_r <= ARB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lock_arbiter.sv
// Directed self-checking bench for mem_lock_arbiter.
module tb_mem_lock_arbiter;

    localparam int C = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [C-1:0]    main_mem_read_request;
    logic [C-1:0]    main_mem_write_request;
    logic [16*C-1:0] req_read_adr;
    logic [16*C-1:0] req_write_adr;
    logic [16*C-1:0] req_write_dat;
    logic [C-1:0]    main_mem_ac;
    logic [15:0]     mem_read_adr;
    logic [15:0]     mem_write_adr;
    logic [15:0]     mem_write_dat;
    logic            mem_write;
    logic [C-1:0]    lock_en;
    logic [C-1:0]    unlock_en;
    logic [10*C-1:0] lock_adr;
    logic [C-1:0]    lock_ac;

    int tests = 0;
    int fails = 0;
    int core;

    mem_lock_arbiter #(.C(C), .LOCKS(8)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .main_mem_read_request  (main_mem_read_request),
        .main_mem_write_request (main_mem_write_request),
        .req_read_adr           (req_read_adr),
        .req_write_adr          (req_write_adr),
        .req_write_dat          (req_write_dat),
        .main_mem_ac            (main_mem_ac),
        .mem_read_adr           (mem_read_adr),
        .mem_write_adr          (mem_write_adr),
        .mem_write_dat          (mem_write_dat),
        .mem_write              (mem_write),
        .lock_en                (lock_en),
        .unlock_en              (unlock_en),
        .lock_adr               (lock_adr),
        .lock_ac                (lock_ac)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        main_mem_read_request  = '0;
        main_mem_write_request = '0;
        req_read_adr  = '0;
        req_write_adr = '0;
        req_write_dat = '0;
        lock_en   = '0;
        unlock_en = '0;
        lock_adr  = '0;
        step();
        step();
        chk("rst_mem_ac", 32'(main_mem_ac), 32'h0);
        chk("rst_lock_ac", 32'(lock_ac), 32'h0);
        chk("rst_mem_write", 32'(mem_write), 32'h0);
        chk("rst_wr_adr", 32'(mem_write_adr), 32'h0);
        chk("rst_rd_adr", 32'(mem_read_adr), 32'h0);
        chk("rst_wr_dat", 32'(mem_write_dat), 32'h0);
        reset = 1'b0;

        // Single write from core 3
        main_mem_write_request[3] = 1'b1;
        req_write_adr[16*3 +: 16] = 16'h0010;
        req_write_dat[16*3 +: 16] = 16'hBEEF;
        step();
        chk("w3_ac", 32'(main_mem_ac), 32'h08);
        chk("w3_we", 32'(mem_write), 32'h1);
        chk("w3_adr", 32'(mem_write_adr), 32'h0010);
        chk("w3_dat", 32'(mem_write_dat), 32'hBEEF);
        main_mem_write_request[3] = 1'b0;
        step();
        chk("w3_ac_off", 32'(main_mem_ac), 32'h0);
        chk("w3_we_off", 32'(mem_write), 32'h0);
        chk("w3_adr_hold", 32'(mem_write_adr), 32'h0010);

        // All reads held: grants rotate 0..7 then 0, every other cycle
        do_reset();
        for (int i = 0; i < C; i++) req_read_adr[16*i +: 16] = 16'(256 * i + 1);
        main_mem_read_request = 8'hFF;
        for (int c = 1; c <= 18; c++) begin
            step();
            if (c % 2 == 1) begin
                core = ((c - 1) / 2) % C;
                chk("rr_ac", 32'(main_mem_ac), 32'(1 << core));
                chk("rr_rd_adr", 32'(mem_read_adr), 32'(256 * core + 1));
            end else begin
                chk("rr_ac_gap", 32'(main_mem_ac), 32'h0);
            end
        end
        chk("rr_we", 32'(mem_write), 32'h0);
        main_mem_read_request = '0;

        // Lock contention on 0x155
        lock_adr[10*0 +: 10] = 10'h155;
        lock_en[0] = 1'b1;
        step();
        chk("l0_ack", 32'(lock_ac), 32'h01);
        lock_en[0] = 1'b0;
        step();
        chk("l0_ack_off", 32'(lock_ac), 32'h0);
        lock_adr[10*5 +: 10] = 10'h155;
        lock_en[5] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("l5_blocked", 32'(lock_ac), 32'h0);
        end
        unlock_en[0] = 1'b1;
        step();
        chk("u0_ack", 32'(lock_ac), 32'h01);
        unlock_en[0] = 1'b0;
        step();
        chk("u0_ack_off", 32'(lock_ac), 32'h0);
        step();
        chk("l5_ack", 32'(lock_ac), 32'h20);
        lock_en[5] = 1'b0;
        step();
        chk("l5_ack_off", 32'(lock_ac), 32'h0);

        // Fill the table, then a ninth lock waits for an unlock
        do_reset();
        for (int i = 0; i < C; i++) lock_adr[10*i +: 10] = 10'(256 + i);
        lock_en = 8'hFF;
        for (int c = 1; c <= 16; c++) begin
            step();
            if (c % 2 == 1) begin
                core = (c - 1) / 2;
                chk("fill_ack", 32'(lock_ac), 32'(1 << core));
                lock_en[core] = 1'b0;
            end else begin
                chk("fill_gap", 32'(lock_ac), 32'h0);
            end
        end
        lock_adr[10*0 +: 10] = 10'h200;
        lock_en[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("full_blocked", 32'(lock_ac), 32'h0);
        end
        unlock_en[3] = 1'b1;
        step();
        chk("u3_ack", 32'(lock_ac), 32'h08);
        unlock_en[3] = 1'b0;
        step();
        chk("u3_ack_off", 32'(lock_ac), 32'h0);
        step();
        chk("l0_new_ack", 32'(lock_ac), 32'h01);
        lock_en[0] = 1'b0;
        step();
        chk("l0_new_off", 32'(lock_ac), 32'h0);

        // Lock+unlock on one core: unlock wins and frees the entry
        do_reset();
        lock_adr[10*2 +: 10] = 10'h020;
        lock_en[2] = 1'b1;
        step();
        chk("l2_ack", 32'(lock_ac), 32'h04);
        lock_en[2] = 1'b0;
        step();
        chk("l2_ack_off", 32'(lock_ac), 32'h0);
        lock_en[2]   = 1'b1;
        unlock_en[2] = 1'b1;
        lock_adr[10*4 +: 10] = 10'h020;
        lock_en[4] = 1'b1;
        step();
        chk("lu2_ack", 32'(lock_ac), 32'h04);
        lock_en[2]   = 1'b0;
        unlock_en[2] = 1'b0;
        step();
        chk("lu2_ack_off", 32'(lock_ac), 32'h0);
        step();
        chk("l4_ack", 32'(lock_ac), 32'h10);
        lock_en[4] = 1'b0;
        step();
        chk("l4_ack_off", 32'(lock_ac), 32'h0);

        // Reset during a write grant while core 4 holds 0x020
        main_mem_write_request[5] = 1'b1;
        req_write_adr[16*5 +: 16] = 16'h0055;
        req_write_dat[16*5 +: 16] = 16'h1234;
        step();
        chk("w5_ac", 32'(main_mem_ac), 32'h20);
        chk("w5_we", 32'(mem_write), 32'h1);
        reset = 1'b1;
        main_mem_write_request[5] = 1'b0;
        req_read_adr[16*2 +: 16] = 16'h0222;
        req_read_adr[16*6 +: 16] = 16'h0666;
        main_mem_read_request[2] = 1'b1;
        main_mem_read_request[6] = 1'b1;
        step();
        chk("mr_ac", 32'(main_mem_ac), 32'h0);
        chk("mr_we", 32'(mem_write), 32'h0);
        chk("mr_wr_adr", 32'(mem_write_adr), 32'h0);
        chk("mr_lock_ac", 32'(lock_ac), 32'h0);
        reset = 1'b0;
        lock_adr[10*2 +: 10] = 10'h020;
        lock_en[2] = 1'b1;
        step();
        chk("pr_ac", 32'(main_mem_ac), 32'h04);
        chk("pr_rd_adr", 32'(mem_read_adr), 32'h0222);
        chk("pr_we", 32'(mem_write), 32'h0);
        chk("pr_lock_ac", 32'(lock_ac), 32'h04);
        main_mem_read_request = '0;
        lock_en = '0;
        step();
        chk("end_ac", 32'(main_mem_ac), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_lock_arbiter.md
Name: mem_lock_arbiter

Overview:
Shared-resource arbiter between the C cores and the single data memory / lock table. Each cycle it picks one core's memory request round-robin and steers that core's address, data and write enable to the memory. It returns a one-cycle access grant. Independently it serves lock/unlock requests against an internal table of held 10-bit lock addresses and returns a one-cycle lock acknowledge.

Parameters:
C, 8, number of cores / requesters
LOCKS, 8, lock table entries (simultaneously held locks)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous active-high reset
main_mem_read_request  in  C  per-core read request, held until granted
main_mem_write_request  in  C  per-core write request, held until granted
req_read_adr  in  16*C  per-core read address, core i at [16i+15:16i]
req_write_adr  in  16*C  per-core write address
req_write_dat  in  16*C  per-core write data
main_mem_ac  out  C  one-hot access grant pulse
mem_read_adr  out  16  read address to data memory
mem_write_adr  out  16  write address to data memory
mem_write_dat  out  16  write data to data memory
mem_write  out  1  data memory write enable
lock_en  in  C  per-core lock request, held until acked
unlock_en  in  C  per-core unlock request, held until acked
lock_adr  in  10*C  per-core lock address
lock_ac  out  C  one-hot lock/unlock acknowledge pulse

Behaviour:
- Reset (reset=1 at clk edge): main_mem_ac=0, lock_ac=0, mem_write=0, mem_*_adr/dat=0, state ARB, both round-robin pointers=C-1 (core 0 highest priority first), all lock entries invalid.
- Memory FSM, states ARB and TURN:
  - ARB: req = read_request|write_request. If req!=0, register winner = first set bit scanning from ptr+1 with wrap. Next cycle main_mem_ac[winner]=1, ptr=winner, go TURN. If req==0, stay in ARB.
  - TURN: main_mem_ac pulse cycle; no new decision; go ARB. Throughput is 1 access per 2 cycles; request-to-grant latency is 1 cycle minimum.
  - During the grant cycle only: mem_read_adr/mem_write_adr/mem_write_dat come from the winner's inputs. mem_write = winner's write_request registered at decision time. Read and write from the same core are both served in one grant.
  - Outside the grant cycle: mem_write=0, addresses/data hold their last value.
- Lock path, independent, same 2-state pattern with its own pointer. A requester is core i with lock_en[i]|unlock_en[i]:
  - unlock: clear any valid entry with (adr,owner)==(lock_adr_i,i). Ack always, even if no match.
  - lock, entry (adr,i) already valid: ack, no change (re-entrant).
  - lock, adr held by another core or table full: not eligible this decision, no ack. The pointer is not advanced for it and its request stays pending.
  - lock, otherwise: write to the lowest free entry, ack.
  - lock_en and unlock_en both set on one core: unlock wins, lock ignored for that grant.
  - Eligibility is evaluated against the table state before the decision. One table update per decision.
- lock_ac and main_mem_ac may pulse in the same cycle for the same or different cores.
- Reset mid-grant: pulses drop the next cycle, pending writes are not issued, and all locks are released.

Test Plan:
- Core 3 write req adr 0x0010 dat 0xBEEF, others idle -> next cycle main_mem_ac=0x08, mem_write=1, mem_write_adr=0x0010, mem_write_dat=0xBEEF; following cycle all 0.
- All 8 read requests held continuously -> grants 0x01,0x02,...,0x80,0x01 on every other cycle, never two bits set.
- Core 0 lock 0x155 acked; core 5 lock 0x155 -> no ack while held; core 0 unlock 0x155 -> ack; core 5 acked within 2 decisions.
- Fill LOCKS=8 distinct addresses from cores 0-7; core 0 locks new adr -> no ack until any unlock completes, then ack.
- Core 2 lock_en and unlock_en both set on adr 0x020 it holds -> lock_ac=0x04, entry freed; core 4 lock 0x020 then acked.
- reset asserted during grant of a write -> mem_write=0 next cycle, lock table empty, next grant goes to lowest-numbered requester.
